// File: rtl/pwm_capture.sv
// Line-PWM receiver: measures the pwm_in high time inside each hsync frame and
// returns it as a DWIDTH-bit value over a single-entry valid/ready output.
module pwm_capture #(
    parameter int DWIDTH      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    input  logic              hsync,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              sat,
    output logic              glitch,
    output logic              overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAS = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [DWIDTH-1:0] CNT_ZERO = {DWIDTH{1'b0}};
    localparam logic [DWIDTH-1:0] CNT_MAX  = {DWIDTH{1'b1}};
    localparam logic [DWIDTH-1:0] CNT_ONE  = {{(DWIDTH-1){1'b0}}, 1'b1};

    function automatic logic [DWIDTH-1:0] sat_inc(input logic [DWIDTH-1:0] v);
        logic [DWIDTH-1:0] r;
        if (v == CNT_MAX) begin
            r = CNT_MAX;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic [SYNC_STAGES-1:0] pwm_sync_q;
    logic [SYNC_STAGES-1:0] hs_sync_q;
    logic                   pwm_prev_q;
    logic                   hs_prev_q;

    logic pwm_s;
    logic hsync_s;
    logic hs_rise;
    logic pwm_fall;
    logic pwm_rise;

    state_t            state_q;
    state_t            state_d;
    logic [DWIDTH-1:0] cnt_q;
    logic [DWIDTH-1:0] cnt_d;
    logic              sat_f_q;
    logic              sat_f_d;
    logic              glitch_f_q;
    logic              glitch_f_d;

    logic              pub_valid_q;
    logic              pub_valid_d;
    logic [DWIDTH-1:0] pub_data_q;
    logic [DWIDTH-1:0] pub_data_d;
    logic              pub_sat_q;
    logic              pub_sat_d;
    logic              pub_glitch_q;
    logic              pub_glitch_d;

    logic [DWIDTH-1:0] dout_q;
    logic [DWIDTH-1:0] dout_d;
    logic              dvalid_q;
    logic              dvalid_d;
    logic              osat_q;
    logic              osat_d;
    logic              oglitch_q;
    logic              oglitch_d;
    logic              overrun_q;
    logic              overrun_d;

    assign pwm_s    = pwm_sync_q[SYNC_STAGES-1];
    assign hsync_s  = hs_sync_q[SYNC_STAGES-1];
    assign hs_rise  = hsync_s & ~hs_prev_q;
    assign pwm_fall = ~pwm_s & pwm_prev_q;
    assign pwm_rise = pwm_s & ~pwm_prev_q;

    // Input synchronizers plus one-cycle history for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_sync_q <= {SYNC_STAGES{1'b0}};
            hs_sync_q  <= {SYNC_STAGES{1'b0}};
            pwm_prev_q <= 1'b0;
            hs_prev_q  <= 1'b0;
        end else begin
            pwm_sync_q <= {pwm_sync_q[SYNC_STAGES-2:0], pwm_in};
            hs_sync_q  <= {hs_sync_q[SYNC_STAGES-2:0], hsync};
            pwm_prev_q <= pwm_s;
            hs_prev_q  <= hsync_s;
        end
    end

    // Measurement FSM next state; a frame boundary outranks every pwm event.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sat_f_d      = sat_f_q;
        glitch_f_d   = glitch_f_q;
        pub_valid_d  = 1'b0;
        pub_data_d   = pub_data_q;
        pub_sat_d    = pub_sat_q;
        pub_glitch_d = pub_glitch_q;
        if (hs_rise && (state_q != ST_IDLE)) begin
            pub_valid_d  = 1'b1;
            pub_data_d   = cnt_q;
            pub_sat_d    = sat_f_q;
            pub_glitch_d = glitch_f_q;
            // A high sample coinciding with hsync belongs to the new frame.
            cnt_d        = pwm_s ? CNT_ONE : CNT_ZERO;
            sat_f_d      = 1'b0;
            glitch_f_d   = 1'b0;
            state_d      = ST_MEAS;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hs_rise) begin
                        cnt_d      = CNT_ZERO;
                        sat_f_d    = 1'b0;
                        glitch_f_d = 1'b0;
                        state_d    = ST_MEAS;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MEAS: begin
                    if (pwm_s) begin
                        cnt_d   = sat_inc(cnt_q);
                        sat_f_d = sat_f_q | (cnt_d == CNT_MAX);
                    end else if (pwm_fall && (cnt_q != CNT_ZERO)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MEAS;
                    end
                end
                ST_DONE: begin
                    if (pwm_rise) begin
                        glitch_f_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    cnt_d      = CNT_ZERO;
                    sat_f_d    = 1'b0;
                    glitch_f_d = 1'b0;
                end
            endcase
        end
    end

    // Measurement state and the registered frame result handed to the output stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            sat_f_q      <= 1'b0;
            glitch_f_q   <= 1'b0;
            pub_valid_q  <= 1'b0;
            pub_data_q   <= CNT_ZERO;
            pub_sat_q    <= 1'b0;
            pub_glitch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sat_f_q      <= sat_f_d;
            glitch_f_q   <= glitch_f_d;
            pub_valid_q  <= pub_valid_d;
            pub_data_q   <= pub_data_d;
            pub_sat_q    <= pub_sat_d;
            pub_glitch_q <= pub_glitch_d;
        end
    end

    // Single-entry output slot; a result arriving while the slot is held unaccepted is dropped.
    always_comb begin
        dout_d    = dout_q;
        dvalid_d  = dvalid_q;
        osat_d    = osat_q;
        oglitch_d = oglitch_q;
        overrun_d = overrun_q;
        if (pub_valid_q) begin
            if (!dvalid_q || data_ready) begin
                dout_d    = pub_data_q;
                osat_d    = pub_sat_q;
                oglitch_d = pub_glitch_q;
                dvalid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dvalid_q && data_ready) begin
            dvalid_d = 1'b0;
        end else begin
            dvalid_d = dvalid_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_q    <= CNT_ZERO;
            dvalid_q  <= 1'b0;
            osat_q    <= 1'b0;
            oglitch_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            dvalid_q  <= dvalid_d;
            osat_q    <= osat_d;
            oglitch_q <= oglitch_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dvalid_q;
    assign sat        = osat_q;
    assign glitch     = oglitch_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed frame table, handshake corner sequences and a
// random waveform scored against a frame-level reference model.
module tb_pwm_capture;

    localparam int DW  = 8;
    localparam int SS  = 2;
    localparam int NW  = 5000;
    localparam int OBS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_in;
    logic          hsync;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready;
    logic          sat;
    logic          glitch;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int period;
        int s;
        int l1;
        int gap;
        int l2;
        int exp_data;
        int exp_sat;
        int exp_gl;
    } vec_t;

    typedef struct {
        int d;
        int s;
        int g;
    } res_t;

    vec_t tbl[8];
    res_t exp_q[$];
    int   rises[$];
    bit   hs_w[NW];
    bit   pw_w[NW];

    logic obs_dv[OBS];
    int   obs_data[OBS];
    logic obs_sat[OBS];
    logic obs_gl[OBS];
    logic obs_ov[OBS];

    pwm_capture #(.DWIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .hsync      (hsync),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .sat        (sat),
        .glitch     (glitch),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        hsync      = 1'b0;
        pwm_in     = 1'b0;
        data_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, int'(data_out), 0);
        check({tag, "_valid"}, int'(data_valid), 0);
        check({tag, "_sat"}, int'(sat), 0);
        check({tag, "_glitch"}, int'(glitch), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    // One hsync frame: hsync high for 3 clocks, pwm high for [s, s+l1) and optionally a second pulse.
    task automatic drive_frame(input int period, s, l1, gap, l2, input logic rdy, input int pulse);
        for (int c = 0; c < period; c++) begin
            if (c < OBS) begin
                obs_dv[c]   = data_valid;
                obs_data[c] = int'(data_out);
                obs_sat[c]  = sat;
                obs_gl[c]   = glitch;
                obs_ov[c]   = overrun;
            end
            hsync      = (c < 3);
            pwm_in     = ((c >= s) && (c < s + l1)) ||
                         ((l2 > 0) && (c >= s + l1 + gap) && (c < s + l1 + gap + l2));
            data_ready = (c == pulse) ? 1'b1 : rdy;
            tick();
        end
    endtask

    function automatic int dv_count();
        int n = 0;
        for (int c = 0; c < OBS; c++) n += int'(obs_dv[c]);
        return n;
    endfunction

    function automatic int rand_run();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(1, 6));
        return int'($urandom_range(5, 320));
    endfunction

    task automatic gen_wave();
        int t;
        int rem;
        bit lvl;
        for (int i = 0; i < NW; i++) hs_w[i] = 1'b0;
        rises.delete();
        t = 5;
        while (t + 330 < NW) begin
            rises.push_back(t);
            t += int'($urandom_range(24, 320));
        end
        rises.push_back(t);
        foreach (rises[k]) for (int j = 0; j < 3; j++) hs_w[rises[k] + j] = 1'b1;
        lvl = 1'b0;
        rem = rand_run();
        for (int i = 0; i < NW; i++) begin
            pw_w[i] = lvl;
            rem--;
            if (rem == 0) begin
                lvl = ~lvl;
                rem = rand_run();
            end
        end
    endtask

    // Frame result = length of the first high run (saturating), glitch = any later high sample.
    task automatic build_expect();
        exp_q.delete();
        for (int k = 1; k < rises.size(); k++) begin
            int  cnt = 0;
            bit  started = 1'b0;
            bit  ended = 1'b0;
            bit  gl = 1'b0;
            bit  v;
            res_t r;
            for (int i = rises[k-1]; i < rises[k]; i++) begin
                v = pw_w[i];
                if (k == 1 && i == rises[0]) v = 1'b0;
                if (!ended) begin
                    if (v) begin
                        started = 1'b1;
                        cnt++;
                    end else if (started) begin
                        ended = 1'b1;
                    end
                end else if (v) begin
                    gl = 1'b1;
                end
            end
            r.d = (cnt > 255) ? 255 : cnt;
            r.s = (cnt >= 255) ? 1 : 0;
            r.g = int'(gl);
            exp_q.push_back(r);
        end
    endtask

    initial begin
        logic rdy;
        bit   prev_hold;
        int   prev_data;
        int   prev_sat;
        int   prev_gl;
        int   got;
        res_t r;

        tbl[0] = '{300, 10,   5, 0, 0,   5, 0, 0};
        tbl[1] = '{300, 10, 200, 0, 0, 200, 0, 0};
        tbl[2] = '{300, 10,   0, 0, 0,   0, 0, 0};
        tbl[3] = '{500, 10, 400, 0, 0, 255, 1, 0};
        tbl[4] = '{100, 10,  10, 5, 7,  10, 0, 1};
        tbl[5] = '{100, 10,  90, 0, 0,  90, 0, 0};
        tbl[6] = '{ 60,  0,  20, 0, 0,  20, 0, 0};
        tbl[7] = '{ 40,  0,   0, 0, 0,   0, 0, 0};

        do_reset();
        check_all_zero("reset");

        for (int k = 0; k < 8; k++) begin
            drive_frame(tbl[k].period, tbl[k].s, tbl[k].l1, tbl[k].gap, tbl[k].l2, 1'b1, -1);
            if (k == 0) begin
                check("first_frame_no_result", dv_count(), 0);
            end else begin
                check($sformatf("tbl%0d_valid_early", k - 1), int'(obs_dv[SS+1]), 0);
                check($sformatf("tbl%0d_valid", k - 1), int'(obs_dv[SS+2]), 1);
                check($sformatf("tbl%0d_data", k - 1), obs_data[SS+2], tbl[k-1].exp_data);
                check($sformatf("tbl%0d_sat", k - 1), int'(obs_sat[SS+2]), tbl[k-1].exp_sat);
                check($sformatf("tbl%0d_glitch", k - 1), int'(obs_gl[SS+2]), tbl[k-1].exp_gl);
            end
        end

        // Two frame ends while the consumer stalls: second result is dropped.
        do_reset();
        drive_frame(60, 10, 12, 0, 0, 1'b0, -1);
        drive_frame(60, 10, 34, 0, 0, 1'b0, -1);
        check("ovr_first_valid", int'(obs_dv[SS+2]), 1);
        check("ovr_first_data", obs_data[SS+2], 12);
        check("ovr_first_overrun", int'(obs_ov[SS+2]), 0);
        drive_frame(40, 0, 0, 0, 0, 1'b0, -1);
        check("ovr_held_valid", int'(data_valid), 1);
        check("ovr_held_data", int'(data_out), 12);
        check("ovr_sticky", int'(overrun), 1);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("ovr_accept_valid", int'(data_valid), 0);
        check("ovr_accept_data", int'(data_out), 12);
        check("ovr_after_accept", int'(overrun), 1);

        // Accept and publish in the same cycle.
        do_reset();
        drive_frame(60, 10, 20, 0, 0, 1'b0, -1);
        drive_frame(60, 10, 40, 0, 0, 1'b0, -1);
        drive_frame(40, 0, 0, 0, 0, 1'b0, SS + 1);
        check("same_pre_valid", int'(obs_dv[SS+1]), 1);
        check("same_pre_data", obs_data[SS+1], 20);
        check("same_post_valid", int'(obs_dv[SS+2]), 1);
        check("same_post_data", obs_data[SS+2], 40);
        check("same_overrun", int'(overrun), 0);
        check("same_end_data", int'(data_out), 40);

        // Reset in the middle of a measurement with a result held.
        do_reset();
        drive_frame(60, 10, 7, 0, 0, 1'b0, -1);
        for (int c = 0; c < 55; c++) begin
            hsync  = (c < 3);
            pwm_in = 1'b1;
            tick();
        end
        check("mid_pre_valid", int'(data_valid), 1);
        check("mid_pre_data", int'(data_out), 7);
        rst = 1'b0;
        tick();
        rst    = 1'b1;
        pwm_in = 1'b0;
        check_all_zero("mid_reset");
        repeat (10) tick();
        drive_frame(60, 10, 33, 0, 0, 1'b1, -1);
        check("mid_first_no_result", dv_count(), 0);
        drive_frame(40, 0, 0, 0, 0, 1'b1, -1);
        check("mid_next_valid", int'(obs_dv[SS+2]), 1);
        check("mid_next_data", obs_data[SS+2], 33);

        // Random waveform against the frame-level model.
        gen_wave();
        build_expect();
        do_reset();
        prev_hold = 1'b0;
        prev_data = 0;
        prev_sat  = 0;
        prev_gl   = 0;
        got       = 0;
        for (int t = 0; t < NW + 40; t++) begin
            if (prev_hold) begin
                check("rand_hold_valid", int'(data_valid), 1);
                check("rand_hold_data", int'(data_out), prev_data);
                check("rand_hold_sat", int'(sat), prev_sat);
                check("rand_hold_glitch", int'(glitch), prev_gl);
            end
            rdy = ($urandom_range(0, 1) == 1) || (t % 8 == 0) || (t >= NW);
            if (data_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_extra_result actual=%0d required=none", int'(data_out));
                end else begin
                    r = exp_q.pop_front();
                    check($sformatf("rand%0d_data", got), int'(data_out), r.d);
                    check($sformatf("rand%0d_sat", got), int'(sat), r.s);
                    check($sformatf("rand%0d_glitch", got), int'(glitch), r.g);
                    got++;
                end
            end
            prev_hold = data_valid && !rdy;
            prev_data = int'(data_out);
            prev_sat  = int'(sat);
            prev_gl   = int'(glitch);
            hsync      = (t < NW) ? hs_w[t] : 1'b0;
            pwm_in     = (t < NW) ? pw_w[t] : 1'b0;
            data_ready = rdy;
            tick();
        end
        check("rand_pending_results", exp_q.size(), 0);
        check("rand_overrun", int'(overrun), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
